// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Five-stage MIPS hazard/stall controller. Handles load-use bubbles,
//            branch flushes and memory-wait freezes with a timeout error, and
//            keeps saturating stall and flush statistics.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 16          // legal range 2..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        EXMEM_Branch,
    input  logic        EXMEM_Zero,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic        pipe_en,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0]  WCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic w_lu;
    logic w_br;
    logic w_mstall;
    logic w_decode;

    logic w_pcwrite;
    logic w_ifidwrite;
    logic w_bubble;
    logic w_flush;
    logic w_pipe_en;
    logic w_err;

    assign w_lu     = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign w_br     = EXMEM_Branch & EXMEM_Zero;
    assign w_mstall = mem_req & ~mem_ready;

    // Next-state and Mealy outputs. w_decode marks cycles that behave like
    // an unstalled RUN cycle (normal RUN or the MEM_WAIT release cycle).
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        w_decode    = 1'b0;
        w_pcwrite   = 1'b1;
        w_ifidwrite = 1'b1;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_pipe_en   = 1'b1;
        w_err       = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_mstall) begin
                    w_pcwrite   = 1'b0;
                    w_ifidwrite = 1'b0;
                    w_pipe_en   = 1'b0;
                    state_d     = S_MEM_WAIT;
                    wcnt_d      = 8'd1;
                end else begin
                    w_decode = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_ready) begin
                    w_pcwrite   = 1'b0;
                    w_ifidwrite = 1'b0;
                    w_pipe_en   = 1'b0;
                    wcnt_d      = wcnt_q + 8'd1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = S_ERROR;
                    end
                end else begin
                    w_decode = 1'b1;
                    state_d  = S_RUN;
                    wcnt_d   = 8'd0;
                end
            end
            S_ERROR: begin
                w_pcwrite   = 1'b0;
                w_ifidwrite = 1'b0;
                w_pipe_en   = 1'b0;
                w_err       = 1'b1;
            end
            default: begin
                w_pcwrite   = 1'b0;
                w_ifidwrite = 1'b0;
                w_pipe_en   = 1'b0;
                state_d     = S_RUN;
                wcnt_d      = 8'd0;
            end
        endcase

        // A taken branch discards the decode instruction, so it masks load-use.
        if (w_decode) begin
            if (w_br) begin
                w_flush = 1'b1;
            end else if (w_lu) begin
                w_pcwrite   = 1'b0;
                w_ifidwrite = 1'b0;
                w_bubble    = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((!w_pipe_en || w_bubble) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (w_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wcnt_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are held low for as long as reset is asserted.
    assign PCWrite     = rst_n & w_pcwrite;
    assign IFIDWrite   = rst_n & w_ifidwrite;
    assign IDEX_Bubble = rst_n & w_bubble;
    assign IFID_Flush  = rst_n & w_flush;
    assign IDEX_Flush  = rst_n & w_flush;
    assign EXMEM_Flush = rst_n & w_flush;
    assign pipe_en     = rst_n & w_pipe_en;
    assign mem_err     = rst_n & w_err;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (TIMEOUT = 4): vector table
//            plus hand-written multi-cycle sequences, scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
    logic        IDEX_MemRead, EXMEM_Branch, EXMEM_Zero, mem_req, mem_ready;
    logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush;
    logic        EXMEM_Flush, pipe_en, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [7:0]  w_outs;

    int ntests = 0;
    int nfail  = 0;

    hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .pipe_en(pipe_en), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, pipe_en, mem_err}
    assign w_outs = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush,
                     IDEX_Flush, EXMEM_Flush, pipe_en, mem_err};

    localparam logic [7:0] O_NORM   = 8'b1100_0010;
    localparam logic [7:0] O_LU     = 8'b0010_0010;
    localparam logic [7:0] O_BR     = 8'b1101_1110;
    localparam logic [7:0] O_FREEZE = 8'b0000_0000;
    localparam logic [7:0] O_ERR    = 8'b0000_0001;

    typedef struct {
        logic        mr;
        logic [4:0]  idex_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        br;
        logic        zero;
        logic        mreq;
        logic        mrdy;
        logic [7:0]  outs;
        logic [15:0] st;
        logic [15:0] fl;
    } vec_t;

    vec_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic mr, input logic [4:0] irt,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic br, input logic z,
                                input logic mq, input logic my,
                                input logic [7:0] o, input logic [15:0] st,
                                input logic [15:0] fl);
        vec_t v;
        v.mr = mr; v.idex_rt = irt; v.rs = rs; v.rt = rt;
        v.br = br; v.zero = z; v.mreq = mq; v.mrdy = my;
        v.outs = o; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic cmp8(input string name, input logic [7:0] got, input logic [7:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic cmp16(input string name, input logic [15:0] got, input logic [15:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        IDEX_MemRead = v.mr;   IDEX_Rt    = v.idex_rt;
        IFID_Rs      = v.rs;   IFID_Rt    = v.rt;
        EXMEM_Branch = v.br;   EXMEM_Zero = v.zero;
        mem_req      = v.mreq; mem_ready  = v.mrdy;
        exp_q.push_back(v);
    endtask

    task automatic check(input string name);
        vec_t e;
        if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL %s: scoreboard empty, got outs %b", name, w_outs);
        end else begin
            e = exp_q.pop_front();
            cmp8({name, ".outs"}, w_outs, e.outs);
            cmp16({name, ".stall_cnt"}, stall_cnt, e.st);
            cmp16({name, ".flush_cnt"}, flush_cnt, e.fl);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        check(name);
    endtask

    task automatic set_idle();
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        EXMEM_Branch = 1'b0; EXMEM_Zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    vec_t  tbl[12];
    string tnm[12];

    initial begin
        rst_n = 1'b0;
        set_idle();

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0); tnm[0]  = "normal";
        tbl[1]  = mk(1, 8, 8, 3, 0, 0, 0, 0, O_LU,   0, 0); tnm[1]  = "lu_rs";
        tbl[2]  = mk(0, 8, 8, 3, 0, 0, 0, 0, O_NORM, 1, 0); tnm[2]  = "after_lu";
        tbl[3]  = mk(1, 5, 2, 5, 0, 0, 0, 0, O_LU,   1, 0); tnm[3]  = "lu_rt";
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 2, 0); tnm[4]  = "reg0";
        tbl[5]  = mk(1, 7, 6, 9, 0, 0, 0, 0, O_NORM, 2, 0); tnm[5]  = "no_match";
        tbl[6]  = mk(1, 8, 8, 8, 1, 1, 0, 0, O_BR,   2, 0); tnm[6]  = "br_and_lu";
        tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, O_NORM, 2, 1); tnm[7]  = "br_not_taken";
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 2, 1); tnm[8]  = "req_ready_same";
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, O_NORM, 2, 1); tnm[9]  = "ready_no_req";
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 0, 0, O_BR,   2, 1); tnm[10] = "br_only";
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 2, 2); tnm[11] = "normal_end";

        // Reset state, with outputs forced low.
        #2;
        cmp8("reset.outs", w_outs, 8'h00);
        cmp16("reset.stall_cnt", stall_cnt, 16'd0);
        cmp16("reset.flush_cnt", flush_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], tnm[i]);
        end

        // Timeout: RUN detect + 3 MEM_WAIT cycles frozen, then ERROR.
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 2, 2), "to_c1");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 3, 2), "to_c2");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 4, 2), "to_c3");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 5, 2), "to_c4");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_ERR,    6, 2), "to_err1");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, O_ERR,    7, 2), "to_err2");

        // Asynchronous reset pulse in the middle of a cycle.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp8("async_rst.outs", w_outs, 8'h00);
        cmp16("async_rst.stall_cnt", stall_cnt, 16'd0);
        cmp16("async_rst.flush_cnt", flush_cnt, 16'd0);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0), "post_rst");

        // Memory wait with a taken branch held; branch acts in release cycle.
        step(mk(0, 0, 0, 0, 1, 1, 1, 0, O_FREEZE, 0, 0), "mw_c1");
        step(mk(0, 0, 0, 0, 1, 1, 1, 0, O_FREEZE, 1, 0), "mw_c2");
        step(mk(0, 0, 0, 0, 1, 1, 1, 0, O_FREEZE, 2, 0), "mw_c3");
        step(mk(0, 0, 0, 0, 1, 1, 1, 1, O_BR,     3, 0), "mw_release");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   3, 1), "mw_after");

        // Saturation: park in ERROR long enough to exceed 65535 stall cycles.
        @(negedge clk);
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        repeat (65600) @(posedge clk);
        @(negedge clk);
        #1;
        cmp16("sat.stall_cnt", stall_cnt, 16'hFFFF);
        cmp8("sat.outs", w_outs, O_ERR);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        cmp16("sat_hold.stall_cnt", stall_cnt, 16'hFFFF);
        cmp16("sat_hold.flush_cnt", flush_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS datapath. Observes the IF/ID instruction fields, the ID/EX control outputs of the `buffer2` stage register, EX/MEM branch resolution, and the data-memory handshake. It then sequences the pipeline:

- PC and IF/ID write enables;
- bubble insertion into ID/EX;
- stage flushes;
- a global freeze while data memory is busy, with a timeout into a sticky error state.

It also keeps saturating stall and flush statistics.

## Interface

**Parameters**
- `TIMEOUT`, default 16: maximum consecutive memory-wait cycles before error; legal range 2..255.

**Ports**
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `IFID_Rs`  in  5  rs field of the instruction in decode.
- `IFID_Rt`  in  5  rt field of the instruction in decode.
- `IDEX_MemRead`  in  1  MemRead currently held in ID/EX.
- `IDEX_Rt`  in  5  destination rt of the instruction in ID/EX.
- `EXMEM_Branch`  in  1  Branch held in EX/MEM.
- `EXMEM_Zero`  in  1  ALU zero held in EX/MEM.
- `mem_req`  in  1  MEM stage is accessing data memory (MemRead or MemToWrite).
- `mem_ready`  in  1  data memory completes the access this cycle.
- `PCWrite`  out  1  PC load enable.
- `IFIDWrite`  out  1  IF/ID load enable.
- `IDEX_Bubble`  out  1  zero all control fields loaded into ID/EX at the next edge.
- `IFID_Flush`  out  1  clear IF/ID at the next edge.
- `IDEX_Flush`  out  1  clear ID/EX at the next edge.
- `EXMEM_Flush`  out  1  clear EX/MEM at the next edge.
- `pipe_en`  out  1  global enable for all stage registers; 0 freezes the pipeline.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  16  saturating count of stall cycles.
- `flush_cnt`  out  16  saturating count of branch flushes.

## Operation

**States**
- RUN, MEM_WAIT, ERROR.
- Internal wait counter `wcnt` is 8 bits.

**Derived terms**
- `lu` = IDEX_MemRead & (IDEX_Rt != 0) & (IDEX_Rt == IFID_Rs | IDEX_Rt == IFID_Rt).
- `br` = EXMEM_Branch & EXMEM_Zero.
- `mstall` = mem_req & ~mem_ready.

**Priority, evaluated in RUN:** mstall > br > lu > normal.
- **normal:** PCWrite = IFIDWrite = pipe_en = 1; all flush and bubble outputs 0.
- **mstall:**
  - Outputs: pipe_en = PCWrite = IFIDWrite = 0; flushes and bubble 0.
  - Next state MEM_WAIT; wcnt <= 1.
- **br:**
  - Outputs: pipe_en = 1, PCWrite = 1, IFIDWrite = 1, IFID_Flush = IDEX_Flush = EXMEM_Flush = 1.
  - lu is ignored because the instruction in decode is discarded.
- **lu:**
  - Outputs: pipe_en = 1, PCWrite = 0, IFIDWrite = 0, IDEX_Bubble = 1.
  - Exactly one bubble per hazard, since ID/EX then holds MemRead = 0.

**MEM_WAIT**
- While mem_ready = 0:
  - Outputs as in the mstall case.
  - wcnt increments.
  - When wcnt == TIMEOUT-1 at an edge, go to ERROR.
- When mem_ready = 1 (release cycle):
  - Outputs and counter updates are exactly those of RUN with mstall = 0; br and lu are evaluated that cycle.
  - Next state RUN.

**ERROR**
- pipe_en = PCWrite = IFIDWrite = 0; flushes and bubble 0; mem_err = 1.
- Exits only on reset.

**Counters**
- stall_cnt +1 on every cycle with pipe_en = 0 or IDEX_Bubble = 1, including ERROR cycles.
- flush_cnt +1 on every cycle with IFID_Flush = 1.
- Both saturate at 16'hFFFF; no wrap.

## Timing

- **Decode latency:** outputs are combinational (Mealy) from state and inputs, for zero-latency hazard response. Effects land at the next rising edge.
- **Reset (asynchronous, rst_n = 0):**
  - state = RUN, wcnt = 0, mem_err = 0, stall_cnt = 0, flush_cnt = 0.
  - While rst_n = 0, all outputs are forced to 0, including pipe_en and PCWrite.
  - After deassertion, the first edge operates normally.
- **Reset mid-wait or in ERROR:** immediate return to RUN with counters cleared; an outstanding memory access is abandoned.
- **Handshake:**
  - mem_ready is sampled every cycle.
  - mem_req = mem_ready = 1 in the same RUN cycle means no stall.
  - mem_ready while mem_req = 0 is ignored.
- **Freeze semantics:** during MEM_WAIT all inputs are frozen by the stalled pipeline. Pending br or lu is therefore handled in the release cycle, never lost.
- **Timeout:** with mem_ready never asserted, the pipeline freezes for exactly TIMEOUT cycles (RUN detect cycle plus TIMEOUT-1 MEM_WAIT cycles); then ERROR.

## Test plan

- **Load-use hazard:**
  - Stimulus: IDEX_MemRead = 1, IDEX_Rt = 8, IFID_Rs = 8.
  - Required: PCWrite = 0, IFIDWrite = 0, IDEX_Bubble = 1 for one cycle. Next cycle, with IDEX_MemRead = 0, normal outputs and stall_cnt = 1.
- **Register $0:** IDEX_Rt = 0 with IFID_Rt = 0 and MemRead = 1 -> no stall.
- **Branch with simultaneous load-use:** br = 1 together with lu = 1 -> three flushes = 1, PCWrite = 1, IDEX_Bubble = 0, flush_cnt = 1.
- **Memory wait then release:**
  - Stimulus: mem_req = 1 with mem_ready = 0 for 3 cycles, then 1; br = 1 held throughout.
  - Required: pipe_en = 0 for 3 cycles; in the release cycle pipe_en = 1 with flushes = 1; stall_cnt = 3.
- **Timeout and reset:**
  - Stimulus: TIMEOUT = 4, mem_ready stuck at 0.
  - Required: ERROR after 4 frozen cycles with mem_err = 1. An asynchronous rst_n pulse mid-cycle clears mem_err and the counters immediately.
- **Saturation:** preload via 65 535 or more stall cycles -> stall_cnt holds at 16'hFFFF.
